channel_stage: RTL and testbench
================================

CHANNEL_STAGE -- requirements
Module: channel_stage

Interface
REQ-001 SHALL have parameter N, default 1: data width of the d fields, legal range 1..64.
REQ-002 SHALL have parameter DATALESS, default 0: when 1, the stage carries handshake tokens only and ignores data, as a DatalessChannel.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port in_v, input, 1 bit: upstream valid, driven from a posedge register.
REQ-006 SHALL have port in_d, input, N bits: upstream data, meaningful only while in_v=1.
REQ-007 SHALL have port in_a, output, 1 bit: upstream acknowledge, combinational from internal state only.
REQ-008 SHALL have port out_v, output, 1 bit: downstream valid.
REQ-009 SHALL have port out_d, output, N bits: downstream data.
REQ-010 SHALL have port out_a, input, 1 bit: downstream acknowledge, may be combinational.

Function
REQ-011 SHALL treat a transfer on either side as occurring at a rising clk edge where v=1 and a=1 on that side.
REQ-012 SHALL be a 2-entry, first-in first-out channel buffer that holds a count of 0, 1 or 2 entries.
REQ-013 SHALL set in_a = (count<2) and reset deasserted, with no combinational path from out_a or in_v.
REQ-014 SHALL set out_v = (count>0) and out_d = the oldest entry; out_d SHALL be 0 while count=0.
REQ-015 SHALL have latency 1: a word accepted at edge k SHALL be presented on out_v/out_d from edge k onward, with no same-cycle bypass.
REQ-016 SHALL sustain full throughput, one transfer per cycle, when in_v=1 and out_a=1 continuously after the first word.
REQ-017 SHALL handle a simultaneous push and pop at count=1 by keeping count at 1 and presenting the new word next, preserving order.
REQ-018 SHALL, at count=2, hold in_a=0 even if out_a=1 in the same cycle, so no push occurs.
REQ-019 SHALL, at count=0, pop nothing and leave count unchanged when out_a=1.
REQ-020 SHALL, when out_v=1 and out_a=0, hold out_d stable and keep out_v=1 until the pop.
REQ-021 SHALL, when DATALESS=1, tie out_d to 0, ignore in_d, and keep handshake behaviour identical to DATALESS=0.

Reset
REQ-022 SHALL, while reset=0, force count=0, out_v=0, out_d=0 and in_a=0 immediately, without waiting for a clock edge.
REQ-023 SHALL discard all buffered words when reset asserts mid-operation.
REQ-024 SHALL drive in_a=1 in the first cycle after reset deassertion.

Configuration
REQ-025 SHALL, when macro CHANNEL_STAGE_COUNT_EN is defined, add output xfer_count, 16 bits, which counts downstream transfers, wraps from 0xFFFF to 0, and resets to 0.
REQ-026 SHALL, when CHANNEL_STAGE_COUNT_EN is undefined, omit the xfer_count port entirely and leave all other behaviour identical.

Verification
REQ-027 SHALL cover reset: hold reset=0 with in_v=1 -> in_a=0, out_v=0, out_d=0; release reset -> in_a=1 on the next cycle.
REQ-028 SHALL cover streaming: N=4, push 0x3,0x5,0x9 on consecutive edges with out_a=1 -> out_d shows 3,5,9 on consecutive cycles, one cycle behind the pushes.
REQ-029 SHALL cover backpressure: out_a=0, push 0xA then 0xB -> in_a=0 after the second push and out_d=0xA held; raise out_a -> 0xA then 0xB pop in order.
REQ-030 SHALL cover full plus pop: count=2 with in_v=1 and out_a=1 -> no push that cycle and count becomes 1.
REQ-031 SHALL cover dataless mode: DATALESS=1 with random in_v/out_a timing (0-5 cycle delays) -> pops equal pushes and out_d stays 0 throughout.
REQ-032 SHALL cover the counter: CHANNEL_STAGE_COUNT_EN defined, 65537 transfers -> xfer_count=1.

Source files
------------

// File: rtl/channel_stage.sv
// channel_stage: two-entry first-in first-out channel buffer with valid/ack
// handshakes on both sides.
//
// Handshake: a word moves across a side on a rising clk edge where that
// side's valid and acknowledge are both 1. in_a depends only on the stored
// count and the reset pin. It has no path from in_v or out_a. out_v and out_d
// come straight from stored state.
//
// Parameters:
//   N        - data width of in_d/out_d (1..64)
//   DATALESS - 1: carry handshake tokens only; in_d ignored, out_d tied to 0
//
// Ports:
//   clk        - clock, all state updates on the rising edge
//   reset      - asynchronous, active-low reset
//   in_v/in_d  - upstream valid/data
//   in_a       - upstream acknowledge (count < 2, reset released)
//   out_v      - downstream valid (count > 0)
//   out_d      - downstream data (oldest entry, 0 while empty)
//   out_a      - downstream acknowledge
//   xfer_count - 16-bit wrapping count of downstream transfers; this port
//                exists only when macro CHANNEL_STAGE_COUNT_EN is defined
module channel_stage #(
  parameter int N        = 1,
  parameter int DATALESS = 0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_v,
  input  logic [N-1:0] in_d,
  output logic         in_a,
  output logic         out_v,
  output logic [N-1:0] out_d,
  input  logic         out_a
`ifdef CHANNEL_STAGE_COUNT_EN
  ,
  output logic [15:0]  xfer_count
`endif
);

  logic [1:0]   count_q, count_d;
  // slot0 always holds the oldest entry and slot1 holds the younger one.
  logic [N-1:0] slot0_q, slot0_d;
  logic [N-1:0] slot1_q, slot1_d;
  logic         push, pop;
  logic [N-1:0] wdata;

  assign in_a  = reset && (count_q != 2'd2);
  assign out_v = (count_q != 2'd0);
  assign out_d = out_v ? slot0_q : '0;

  always_comb begin
    push    = in_v && in_a;
    pop     = out_v && out_a;
    wdata   = (DATALESS != 0) ? '0 : in_d;
    count_d = count_q;
    slot0_d = slot0_q;
    slot1_d = slot1_q;
    case ({push, pop})
      2'b10: begin
        if (count_q == 2'd0) slot0_d = wdata;
        else                 slot1_d = wdata;
        count_d = count_q + 2'd1;
      end
      2'b01: begin
        slot0_d = slot1_q;
        slot1_d = '0;
        count_d = count_q - 2'd1;
      end
      // Both a push and a pop can happen only at count 1. Count 0 has no pop,
      // and count 2 has no push. The new word becomes the head.
      2'b11: begin
        slot0_d = wdata;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= 2'd0;
      slot0_q <= '0;
      slot1_q <= '0;
    end else begin
      count_q <= count_d;
      slot0_q <= slot0_d;
      slot1_q <= slot1_d;
    end
  end

`ifdef CHANNEL_STAGE_COUNT_EN
  logic [15:0] xfer_count_q, xfer_count_d;

  // The counter wraps naturally from 0xFFFF to 0.
  always_comb begin
    xfer_count_d = xfer_count_q;
    if (pop) xfer_count_d = xfer_count_q + 16'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) xfer_count_q <= 16'd0;
    else        xfer_count_q <= xfer_count_d;
  end

  assign xfer_count = xfer_count_q;
`endif

endmodule

// File: tb/tb_channel_stage.sv
module tb_channel_stage;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // Main instance: N=4, with data.
  logic       in_v, in_a, out_v, out_a;
  logic [3:0] in_d, out_d;
  // Dataless instance: N=4, DATALESS=1.
  logic       dl_in_v, dl_in_a, dl_out_v, dl_out_a;
  logic [3:0] dl_in_d, dl_out_d;
`ifdef CHANNEL_STAGE_COUNT_EN
  logic [15:0] xfer_count, dl_xfer_count;
`endif

  channel_stage #(.N(4), .DATALESS(0)) dut (
    .clk(clk), .reset(reset),
    .in_v(in_v), .in_d(in_d), .in_a(in_a),
    .out_v(out_v), .out_d(out_d), .out_a(out_a)
`ifdef CHANNEL_STAGE_COUNT_EN
    , .xfer_count(xfer_count)
`endif
  );

  channel_stage #(.N(4), .DATALESS(1)) dut_dl (
    .clk(clk), .reset(reset),
    .in_v(dl_in_v), .in_d(dl_in_d), .in_a(dl_in_a),
    .out_v(dl_out_v), .out_d(dl_out_d), .out_a(dl_out_a)
`ifdef CHANNEL_STAGE_COUNT_EN
    , .xfer_count(dl_xfer_count)
`endif
  );

  // ---------------- scoreboard ----------------
  logic [3:0]  exp_q[$];
  logic [15:0] exp_xfer;
  int          dl_cnt, dl_pushes, dl_pops;
  int          checks = 0;
  int          errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Inputs are driven 1 time unit after the posedge and compared 3 units
  // later. The model's handshake then updates the queue for the next edge.
  task automatic cyc(input logic v, input logic [3:0] d, input logic a);
    logic push, pop;
    in_v = v; in_d = d; out_a = a;
    #3;
    check("in_a", in_a, exp_q.size() < 2);
    check("out_v", out_v, exp_q.size() > 0);
    if (exp_q.size() == 0) check("out_d_empty", out_d, 0);
    else                   check("out_d_head", out_d, exp_q[0]);
    push = v && (exp_q.size() < 2);
    pop  = a && (exp_q.size() > 0);
    if (pop) begin
      void'(exp_q.pop_front());
      exp_xfer = exp_xfer + 16'd1;
    end
    if (push) exp_q.push_back(d);
    @(posedge clk); #1;
  endtask

  task automatic cyc_dl(input logic v, input logic a);
    logic push, pop;
    dl_in_v = v; dl_in_d = 4'($urandom_range(0, 15)); dl_out_a = a;
    #3;
    check("dl_in_a", dl_in_a, dl_cnt < 2);
    check("dl_out_v", dl_out_v, dl_cnt > 0);
    check("dl_out_d_zero", dl_out_d, 0);
    push = v && (dl_cnt < 2);
    pop  = a && (dl_cnt > 0);
    if (pop)  begin dl_cnt--; dl_pops++; end
    if (push) begin dl_cnt++; dl_pushes++; end
    @(posedge clk); #1;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int gap_in, gap_out;
    logic v, a;
    int pops;
    exp_xfer = 16'd0;
    dl_cnt = 0; dl_pushes = 0; dl_pops = 0;
    in_v = 1'b1; in_d = 4'h7; out_a = 1'b1;
    dl_in_v = 1'b1; dl_in_d = 4'h7; dl_out_a = 1'b1;
    reset = 1'b0;

    // Reset held with in_v=1
    #2;
    check("rst_in_a", in_a, 0);
    check("rst_out_v", out_v, 0);
    check("rst_out_d", out_d, 0);
    check("rst_dl_in_a", dl_in_a, 0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_hold_in_a", in_a, 0);
    check("rst_hold_out_v", out_v, 0);
`ifdef CHANNEL_STAGE_COUNT_EN
    check("rst_xfer_count", xfer_count, 0);
`endif
    in_v = 1'b0; out_a = 1'b0; dl_in_v = 1'b0; dl_out_a = 1'b0;
    reset = 1'b1;
    #1;
    check("post_rst_in_a", in_a, 1);
    check("post_rst_out_v", out_v, 0);

    // Empty with out_a=1: nothing pops
    cyc(1'b0, 4'h0, 1'b1);
    cyc(1'b0, 4'h0, 1'b1);
    check("empty_pop_out_v", out_v, 0);

    // Streaming 3, 5, 9 with out_a=1
    cyc(1'b1, 4'h3, 1'b1);
    check("stream_first_out_d", out_d, 4'h3);
    cyc(1'b1, 4'h5, 1'b1);
    check("stream_second_out_d", out_d, 4'h5);
    cyc(1'b1, 4'h9, 1'b1);
    check("stream_third_out_d", out_d, 4'h9);
    cyc(1'b0, 4'h0, 1'b1);
    check("stream_drained", out_v, 0);

    // Backpressure: 0xA then 0xB with out_a=0
    cyc(1'b1, 4'hA, 1'b0);
    cyc(1'b1, 4'hB, 1'b0);
    check("bp_in_a_low", in_a, 0);
    check("bp_out_d_held", out_d, 4'hA);
    cyc(1'b0, 4'h0, 1'b0);
    check("bp_still_held", out_d, 4'hA);
    cyc(1'b0, 4'h0, 1'b1);
    check("bp_second_out", out_d, 4'hB);
    cyc(1'b0, 4'h0, 1'b1);
    check("bp_empty", out_v, 0);

    // Full plus pop: no push in that cycle, count becomes 1
    cyc(1'b1, 4'h1, 1'b0);
    cyc(1'b1, 4'h2, 1'b0);
    cyc(1'b1, 4'hC, 1'b1);
    check("fullpop_in_a", in_a, 1);
    check("fullpop_out_d", out_d, 4'h2);
    cyc(1'b0, 4'h0, 1'b1);
    check("fullpop_no_push", out_v, 0);

    // Push and pop together at count 1
    cyc(1'b1, 4'h4, 1'b0);
    cyc(1'b1, 4'h6, 1'b1);
    check("pushpop_out_d", out_d, 4'h6);
    check("pushpop_in_a", in_a, 1);
    cyc(1'b0, 4'h0, 1'b1);

    // Random traffic on the data instance
    for (int i = 0; i < 200; i++)
      cyc(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));

    // Reset in the middle of operation discards buffered words
    cyc(1'b1, 4'hD, 1'b0);
    cyc(1'b1, 4'hE, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    check("midrst_in_a", in_a, 0);
    check("midrst_out_v", out_v, 0);
    check("midrst_out_d", out_d, 0);
    exp_q.delete();
    exp_xfer = 16'd0;
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    check("midrst_release_in_a", in_a, 1);
    cyc(1'b0, 4'h0, 1'b1);

    // Dataless mode with random 0-5 cycle gaps
    in_v = 1'b0; out_a = 1'b0;
    gap_in = $urandom_range(0, 5);
    gap_out = $urandom_range(0, 5);
    for (int i = 0; i < 300; i++) begin
      v = (gap_in == 0);
      a = (gap_out == 0);
      if (v && dl_cnt < 2) gap_in = $urandom_range(0, 5);
      else if (gap_in > 0) gap_in--;
      if (a && dl_cnt > 0) gap_out = $urandom_range(0, 5);
      else if (gap_out > 0) gap_out--;
      cyc_dl(v, a);
    end
    for (int i = 0; i < 4; i++) cyc_dl(1'b0, 1'b1);
    check("dl_pops_eq_pushes", 64'(dl_pops), 64'(dl_pushes));
    check("dl_empty", dl_out_v, 0);
    dl_in_v = 1'b0; dl_out_a = 1'b0;

`ifdef CHANNEL_STAGE_COUNT_EN
    // Counter wrap: 65537 transfers leave xfer_count at 1
    reset = 1'b0;
    #1;
    check("cnt_rst", xfer_count, 0);
    exp_q.delete();
    exp_xfer = 16'd0;
    @(posedge clk); #1;
    reset = 1'b1;
    pops = 0;
    for (int i = 0; i < 70000 && pops < 65537; i++) begin
      if (exp_q.size() > 0) pops++;
      cyc(1'b1, 4'(i), 1'b1);
    end
    check("cnt_pops_reached", 64'(pops), 64'd65537);
    check("cnt_model", xfer_count, exp_xfer);
    check("cnt_wrap_value", xfer_count, 16'd1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
